// File: rtl/uart_tx_word.sv
// 16-bit word UART transmitter: a small FIFO feeds a serializer that sends each
// word as two back-to-back 8N1 frames, high byte first.
module uart_tx_word #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic        iWrEn,
   input  logic [15:0] iData,
   output logic        oFull,
   output logic        oEmpty,
   output logic        oBusy,
   output logic        oOverflow,
   output logic        oTx
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [PW:0]   CNT_FULL  = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   state_e        state_q;
   logic [15:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q, count_d;
   logic          full_q, empty_q;
   logic          tx_q, busy_q, hi_q;
   logic [15:0]   word_q;
   logic [2:0]    bit_q, nxt_bit;
   logic [BW-1:0] baud_q;
   logic          wr_acc, pop, baud_end;
   logic [7:0]    cur_byte;

   // Acceptance is judged on the registered full flag, so a pop on the same
   // edge never rescues a write that arrives while full.
   assign wr_acc   = iWrEn & ~full_q;
   assign baud_end = (baud_q == BAUD_LAST);
   assign pop      = ~empty_q & ((state_q == IDLE) |
                                 ((state_q == STOP) & baud_end & ~hi_q));
   assign cur_byte = hi_q ? word_q[15:8] : word_q[7:0];
   assign nxt_bit  = bit_q + 3'd1;
   assign count_d  = count_q + (PW+1)'(wr_acc) - (PW+1)'(pop);

   always_ff @(posedge iClock) begin
      if (wr_acc) mem_q[wr_ptr_q] <= iData;
   end

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (wr_acc) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
         full_q  <= (count_d == CNT_FULL);
         empty_q <= (count_d == '0);
      end
   end

   // Baud counter restarts on every state entry so bit edges never drift.
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state_q <= IDLE;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         hi_q    <= 1'b0;
         word_q  <= '0;
         bit_q   <= '0;
         baud_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  word_q  <= mem_q[rd_ptr_q];
                  hi_q    <= 1'b1;
                  baud_q  <= '0;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= START;
               end
            end
            START: begin
               if (baud_end) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  tx_q    <= cur_byte[0];
                  state_q <= DATA;
               end else baud_q <= baud_q + BW'(1);
            end
            DATA: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     bit_q <= nxt_bit;
                     tx_q  <= cur_byte[nxt_bit];
                  end
               end else baud_q <= baud_q + BW'(1);
            end
            STOP: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (hi_q) begin
                     hi_q    <= 1'b0;
                     tx_q    <= 1'b0;
                     state_q <= START;
                  end else if (pop) begin
                     word_q  <= mem_q[rd_ptr_q];
                     hi_q    <= 1'b1;
                     tx_q    <= 1'b0;
                     state_q <= START;
                  end else begin
                     busy_q  <= 1'b0;
                     tx_q    <= 1'b1;
                     state_q <= IDLE;
                  end
               end else baud_q <= baud_q + BW'(1);
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign oFull     = full_q;
   assign oEmpty    = empty_q;
   assign oBusy     = busy_q;
   assign oOverflow = iWrEn & full_q;
   assign oTx       = tx_q;

endmodule

// File: tb/tb_uart_tx_word.sv
// Bench for uart_tx_word: a word-level line model checks a fast-baud instance
// cycle by cycle; a bit-sampling receiver decodes a full-rate instance.
module tb_uart_tx_word;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int CPB2  = 434;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b1, rst2_n = 1'b1;
   logic wr = 1'b0, wr2 = 1'b0;
   logic [15:0] din = '0, din2 = '0;
   logic full, empty, busy, ovf, tx;
   logic full2, empty2, busy2, ovf2, tx2;

   int errors = 0, checks = 0;

   uart_tx_word #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .iClock(clk), .iReset(rst_n), .iWrEn(wr), .iData(din),
      .oFull(full), .oEmpty(empty), .oBusy(busy), .oOverflow(ovf), .oTx(tx));

   uart_tx_word #(.CLKS_PER_BIT(CPB2), .FIFO_DEPTH(DEPTH)) dut2 (
      .iClock(clk), .iReset(rst2_n), .iWrEn(wr2), .iData(din2),
      .oFull(full2), .oEmpty(empty2), .oBusy(busy2), .oOverflow(ovf2), .oTx(tx2));

   // Line model: queue of pending words plus the start cycle of the word on the wire.
   logic [15:0] mq[$];
   logic [15:0] m_w;
   bit          m_active = 0;
   int          m_s = 0, m_idle_from = 0, cyc = 0;
   logic        last_ovf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Word on the wire is 20 bit times: start, hi LSB-first, stop, start, lo, stop.
   function automatic logic frame_bit(input logic [15:0] w, input int b);
      if (b == 0 || b == 10) return 1'b0;
      if (b == 9 || b == 19) return 1'b1;
      if (b < 9) return w[8 + b - 1];
      return w[b - 11];
   endfunction

   function automatic logic m_tx();
      if (!m_active) return 1'b1;
      return frame_bit(m_w, (cyc - m_s) / CPB);
   endfunction

   task automatic model_edge(input logic w_en, input logic [15:0] d);
      int pre;
      pre = mq.size();
      if (m_active && cyc == m_s + 20 * CPB) begin
         if (pre > 0) begin m_w = mq.pop_front(); m_s = cyc; end
         else begin m_active = 0; m_idle_from = cyc + 1; end
      end else if (!m_active && cyc >= m_idle_from && pre > 0) begin
         m_w = mq.pop_front(); m_s = cyc; m_active = 1;
      end
      if (w_en && pre < DEPTH) mq.push_back(d);
   endtask

   // Entered and left 1 time unit after a rising edge.
   task automatic step(input logic w_en, input logic [15:0] d);
      wr = w_en; din = d;
      #1;
      last_ovf = ovf;
      chk("overflow", ovf, (w_en && mq.size() == DEPTH));
      @(posedge clk);
      cyc++;
      model_edge(w_en, d);
      #1;
      chk("tx", tx, m_tx());
      chk("busy", busy, m_active);
      chk("empty", empty, (mq.size() == 0));
      chk("full", full, (mq.size() == DEPTH));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_tx"}, tx, 1'b1);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_empty"}, empty, 1'b1);
      chk({tag, "_full"}, full, 1'b0);
      chk({tag, "_ovf"}, ovf, 1'b0);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((m_active || mq.size() != 0) && guard < 2000) begin
         step(1'b0, 16'h0);
         guard++;
      end
      chk("drain_timeout", (guard < 2000), 1'b1);
      step(1'b0, 16'h0);
   endtask

   typedef struct { int off; logic tx; logic busy; logic empty; } vec_t;

   task automatic main_test();
      vec_t tbl[$];
      int e, ovf_seen;
      tbl.push_back('{0, 1, 0, 0});  tbl.push_back('{1, 0, 1, 1});
      tbl.push_back('{4, 0, 1, 1});  tbl.push_back('{5, 1, 1, 1});
      tbl.push_back('{9, 0, 1, 1});  tbl.push_back('{13, 1, 1, 1});
      tbl.push_back('{17, 0, 1, 1}); tbl.push_back('{21, 0, 1, 1});
      tbl.push_back('{25, 1, 1, 1}); tbl.push_back('{29, 0, 1, 1});
      tbl.push_back('{33, 1, 1, 1}); tbl.push_back('{37, 1, 1, 1});
      tbl.push_back('{40, 1, 1, 1}); tbl.push_back('{41, 0, 1, 1});
      tbl.push_back('{44, 0, 1, 1}); tbl.push_back('{45, 0, 1, 1});
      tbl.push_back('{49, 1, 1, 1}); tbl.push_back('{53, 0, 1, 1});
      tbl.push_back('{57, 1, 1, 1}); tbl.push_back('{61, 1, 1, 1});
      tbl.push_back('{65, 0, 1, 1}); tbl.push_back('{69, 1, 1, 1});
      tbl.push_back('{73, 0, 1, 1}); tbl.push_back('{77, 1, 1, 1});
      tbl.push_back('{80, 1, 1, 1}); tbl.push_back('{81, 1, 0, 1});

      for (int i = 0; i < 50; i++) step(1'b0, 16'h0);
      chk_reset_vals("idle50");

      step(1'b1, 16'hA55A);
      e = cyc;
      for (int k = 0; k <= 85; k++) begin
         if (k > 0) step(1'b0, 16'h0);
         foreach (tbl[j]) if (tbl[j].off == cyc - e) begin
            chk($sformatf("a55a_tx@%0d", tbl[j].off), tx, tbl[j].tx);
            chk($sformatf("a55a_busy@%0d", tbl[j].off), busy, tbl[j].busy);
            chk($sformatf("a55a_empty@%0d", tbl[j].off), empty, tbl[j].empty);
         end
      end

      // Burst of five: the first pop frees a slot, so all five fit.
      ovf_seen = 0;
      step(1'b1, 16'h1234); e = cyc; ovf_seen += last_ovf;
      step(1'b1, 16'hFFFF); ovf_seen += last_ovf;
      step(1'b1, 16'h0000); ovf_seen += last_ovf;
      step(1'b1, 16'h8001); ovf_seen += last_ovf;
      step(1'b1, 16'h00FF); ovf_seen += last_ovf;
      chk("burst_ovf_count", ovf_seen, 0);
      chk("burst_full", full, 1'b1);
      while (cyc < e + 80) step(1'b0, 16'h0);
      step(1'b1, 16'hDEAD);
      chk("popedge_ovf", last_ovf, 1'b1);
      chk("popedge_full", full, 1'b0);
      chk("popedge_busy", busy, 1'b1);
      step(1'b0, 16'h0);
      chk("ovf_one_cycle", last_ovf, 1'b0);
      drain();
      chk("burst_empty_end", empty, 1'b1);

      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 3) == 0), 16'($urandom));
      drain();

      step(1'b1, 16'h3CF7);
      e = cyc + 1;
      while (cyc < e + 57) step(1'b0, 16'h0);
      chk("pre_reset_bit3", tx, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      mq.delete(); m_active = 0; m_idle_from = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("hold_rst");
      cyc += 2;
      rst_n = 1'b1;
      step(1'b1, 16'h00C3);
      e = cyc;
      for (int k = 0; k < 85; k++) step(1'b0, 16'h0);
      chk("c3_idle_end", busy, 1'b0);
   endtask

   task automatic full_rate_test();
      logic [15:0] words [8];
      foreach (words[i]) words[i] = 16'($urandom);
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               int g;
               g = 0;
               @(negedge clk);
               while (full2 && g < 20000) begin @(negedge clk); g++; end
               chk("tx434_full_wait", (g < 20000), 1'b1);
               wr2 = 1'b1; din2 = words[i];
               #1 chk("tx434_ovf", ovf2, 1'b0);
               @(negedge clk);
               wr2 = 1'b0;
            end
         end
         begin
            for (int b = 0; b < 16; b++) begin
               int g;
               logic [7:0] rx, ex;
               g = 0;
               @(negedge clk);
               while (tx2 !== 1'b0 && g < 20000) begin @(negedge clk); g++; end
               if (g >= 20000) begin
                  chk("rx434_timeout", 1'b0, 1'b1);
                  break;
               end
               repeat (CPB2 / 2) @(negedge clk);
               chk("rx434_start", tx2, 1'b0);
               for (int i = 0; i < 8; i++) begin
                  repeat (CPB2) @(negedge clk);
                  rx[i] = tx2;
               end
               repeat (CPB2) @(negedge clk);
               chk("rx434_stop", tx2, 1'b1);
               ex = (b % 2 == 0) ? words[b / 2][15:8] : words[b / 2][7:0];
               chk($sformatf("rx434_byte%0d", b), rx, ex);
            end
            repeat (CPB2) @(negedge clk);
            chk("rx434_empty", empty2, 1'b1);
            chk("rx434_idle", busy2, 1'b0);
         end
      join
   endtask

   initial begin
      #2;
      rst_n = 1'b0; rst2_n = 1'b0;
      #1;
      chk_reset_vals("por");
      chk("por2_tx", tx2, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1; rst2_n = 1'b1;
      fork
         main_test();
         full_rate_test();
      join
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
